// File: rtl/jtopl_mmr_bank.sv
// OPL/OPL2/OPL3 register front end: latches CPU writes, queues data writes in a
// small FIFO and retires one per paced slot into global registers and update strobes.
module jtopl_mmr_bank #(
    parameter int OPL_TYPE  = 3,
    parameter int FIFO_AW   = 2,
    parameter int BUSY_DATA = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cenop,
    input  logic [7:0] din,
    input  logic       write,
    input  logic [1:0] addr,
    output logic       busy,
    output logic       ovf,
    output logic       sel_bank,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic [7:0] data,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_wav,
    output logic       up_fnumlo,
    output logic       up_fnumhi,
    output logic       up_fbcon,
    output logic [7:0] value_A,
    output logic [7:0] value_B,
    output logic       st_A,
    output logic       st_B,
    output logic       flagen_A,
    output logic       flagen_B,
    output logic       clr_flag,
    output logic       am_dep,
    output logic       vib_dep,
    output logic       rhy_en,
    output logic [4:0] rhy_kon,
    output logic       wave_mode,
    output logic       new_mode,
    output logic [5:0] conn_sel
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(BUSY_DATA + 1);

    // Handshake: write is a one-clk strobe with no ready; a data write that finds
    // the queue full (and not popping that clk) is dropped and flagged in ovf.
    logic [7:0]       selreg;
    logic             selbank;
    logic [16:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;

    logic        empty, full, pop, push_req, push;
    logic [16:0] entry;
    logic        e_bank;
    logic [7:0]  e_reg, e_din;
    logic [2:0]  e_hi;
    logic [3:0]  ch;
    logic        op_hit, ch_hit;
    logic [1:0]  ch_group;
    logic [2:0]  ch_sub;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop      = cenop & ~empty & (cnt == '0);
    assign push_req = write & addr[0];
    assign push     = push_req & (~full | pop);
    assign busy     = ~empty | (cnt != '0);

    assign entry  = mem[rd_ptr[FIFO_AW-1:0]];
    assign e_bank = entry[16];
    assign e_reg  = entry[15:8];
    assign e_din  = entry[7:0];
    assign e_hi   = e_reg[7:5];
    assign ch     = e_reg[3:0];

    // Operator slots skip r[2:0]=6,7 and group 3; 0xE0 row exists from OPL2 on.
    assign op_hit = ((e_hi >= 3'd1 && e_hi <= 3'd4) || (OPL_TYPE > 1 && e_hi == 3'd7)) &&
                    (e_reg[2:0] <= 3'd5) && (e_reg[4:3] != 2'd3);
    assign ch_hit = (e_reg[7:4] == 4'hA || e_reg[7:4] == 4'hB || e_reg[7:4] == 4'hC) &&
                    (ch <= 4'd8);
    assign ch_group = (ch < 4'd3) ? 2'd0 : (ch < 4'd6) ? 2'd1 : 2'd2;
    assign ch_sub   = (ch < 4'd6) ? ch[2:0] : {1'b0, ~&ch[2:1], ch[0]};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {selbank, selreg, din};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            selreg    <= '0;
            selbank   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            sel_bank  <= 1'b0;
            sel_group <= '0;
            sel_sub   <= '0;
            data      <= '0;
            up_mult   <= 1'b0;
            up_ksl_tl <= 1'b0;
            up_ar_dr  <= 1'b0;
            up_sl_rr  <= 1'b0;
            up_wav    <= 1'b0;
            up_fnumlo <= 1'b0;
            up_fnumhi <= 1'b0;
            up_fbcon  <= 1'b0;
            value_A   <= '0;
            value_B   <= '0;
            st_A      <= 1'b0;
            st_B      <= 1'b0;
            flagen_A  <= 1'b1;
            flagen_B  <= 1'b1;
            clr_flag  <= 1'b0;
            am_dep    <= 1'b0;
            vib_dep   <= 1'b0;
            rhy_en    <= 1'b0;
            rhy_kon   <= '0;
            wave_mode <= (OPL_TYPE == 3);
            new_mode  <= 1'b0;
            conn_sel  <= '0;
        end else begin
            if (write && !addr[0]) begin
                selreg  <= din;
                selbank <= (OPL_TYPE == 3 && (new_mode || din == 8'h05)) ? addr[1] : 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (push_req && full && !pop) ovf <= 1'b1;
            if (cenop) begin
                clr_flag <= 1'b0;
                if (pop) cnt <= CW'(BUSY_DATA);
                else if (cnt != '0) cnt <= cnt - CW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                data      <= e_din;
                up_mult   <= 1'b0;
                up_ksl_tl <= 1'b0;
                up_ar_dr  <= 1'b0;
                up_sl_rr  <= 1'b0;
                up_wav    <= 1'b0;
                up_fnumlo <= 1'b0;
                up_fnumhi <= 1'b0;
                up_fbcon  <= 1'b0;
                if (!e_bank) begin
                    case (e_reg)
                        8'h01: if (OPL_TYPE == 2) wave_mode <= e_din[5];
                        8'h02: value_A <= e_din;
                        8'h03: value_B <= e_din;
                        8'h04: begin
                            clr_flag <= e_din[7];
                            // A flag-reset write leaves timer control untouched.
                            if (!e_din[7]) begin
                                flagen_A    <= ~e_din[6];
                                flagen_B    <= ~e_din[5];
                                {st_B, st_A} <= e_din[1:0];
                            end
                        end
                        8'hBD: {am_dep, vib_dep, rhy_en, rhy_kon} <= e_din;
                        default: ;
                    endcase
                end else if (OPL_TYPE == 3) begin
                    if (e_reg == 8'h04) conn_sel <= e_din[5:0];
                    if (e_reg == 8'h05) new_mode <= e_din[0];
                end
                if (op_hit) begin
                    {sel_bank, sel_group, sel_sub} <= {e_bank, e_reg[4:3], e_reg[2:0]};
                    case (e_hi)
                        3'd1: up_mult   <= 1'b1;
                        3'd2: up_ksl_tl <= 1'b1;
                        3'd3: up_ar_dr  <= 1'b1;
                        3'd4: up_sl_rr  <= 1'b1;
                        3'd7: up_wav    <= 1'b1;
                        default: ;
                    endcase
                end else if (ch_hit) begin
                    {sel_bank, sel_group, sel_sub} <= {e_bank, ch_group, ch_sub};
                    case (e_reg[7:4])
                        4'hA: up_fnumlo <= 1'b1;
                        4'hB: up_fnumhi <= 1'b1;
                        4'hC: up_fbcon  <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_jtopl_mmr_bank.sv
// Directed bench for jtopl_mmr_bank: register decode, FIFO pacing, overflow,
// OPL3 bank addressing, timer control and reset flush.
module tb_jtopl_mmr_bank;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cenop = 1'b0;
    logic [7:0] din = '0;
    logic       write = 1'b0;
    logic [1:0] addr = '0;
    logic       busy, ovf, sel_bank;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic [7:0] data, value_A, value_B;
    logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, up_fnumlo, up_fnumhi, up_fbcon;
    logic       st_A, st_B, flagen_A, flagen_B, clr_flag, am_dep, vib_dep, rhy_en;
    logic [4:0] rhy_kon;
    logic       wave_mode, new_mode;
    logic [5:0] conn_sel;

    int n_chk = 0;
    int n_fail = 0;

    jtopl_mmr_bank #(.OPL_TYPE(3), .FIFO_AW(2), .BUSY_DATA(24)) dut (
        .clk(clk), .rst(rst), .cenop(cenop), .din(din), .write(write), .addr(addr),
        .busy(busy), .ovf(ovf), .sel_bank(sel_bank), .sel_group(sel_group),
        .sel_sub(sel_sub), .data(data), .up_mult(up_mult), .up_ksl_tl(up_ksl_tl),
        .up_ar_dr(up_ar_dr), .up_sl_rr(up_sl_rr), .up_wav(up_wav),
        .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_fbcon(up_fbcon),
        .value_A(value_A), .value_B(value_B), .st_A(st_A), .st_B(st_B),
        .flagen_A(flagen_A), .flagen_B(flagen_B), .clr_flag(clr_flag),
        .am_dep(am_dep), .vib_dep(vib_dep), .rhy_en(rhy_en), .rhy_kon(rhy_kon),
        .wave_mode(wave_mode), .new_mode(new_mode), .conn_sel(conn_sel)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        write = 1'b1; addr = a; din = d;
        cyc();
        write = 1'b0;
    endtask

    task automatic cen(input int n);
        for (int i = 0; i < n; i++) begin
            cenop = 1'b1;
            cyc();
            cenop = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            cen(1);
            k++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // reset
        repeat (3) cyc();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_flagen", {flagen_A, flagen_B}, 2'b11);
        chk("rst_wave_mode", wave_mode, 1);
        chk("rst_data", data, 0);
        chk("rst_strobes", {up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, up_fnumlo, up_fnumhi, up_fbcon}, 0);

        // single operator write and busy window
        wr(2'b00, 8'h20);
        wr(2'b01, 8'h21);
        chk("t1_busy_after_write", busy, 1);
        cen(1);
        chk("t1_up_mult", up_mult, 1);
        chk("t1_sel", {sel_bank, sel_group, sel_sub}, {1'b0, 2'd0, 3'd0});
        chk("t1_data", data, 8'h21);
        cen(23);
        chk("t1_busy_23", busy, 1);
        cen(1);
        chk("t1_busy_24", busy, 0);

        // fill FIFO, overflow, paced in-order retire
        wr(2'b00, 8'h40);
        wr(2'b01, 8'h11);
        wr(2'b01, 8'h12);
        wr(2'b01, 8'h13);
        wr(2'b01, 8'h14);
        chk("t2_no_ovf_yet", ovf, 0);
        wr(2'b01, 8'h15);
        chk("t2_ovf", ovf, 1);
        cen(1);
        chk("t2_ret0", data, 8'h11);
        chk("t2_ksl_tl", {up_ksl_tl, up_mult}, 2'b10);
        cen(24);
        chk("t2_hold_24", data, 8'h11);
        cen(1);
        chk("t2_ret1", data, 8'h12);
        cen(25);
        chk("t2_ret2", data, 8'h13);
        cen(25);
        chk("t2_ret3", data, 8'h14);
        cen(24);
        chk("t2_drained", busy, 0);
        cen(5);
        chk("t2_no_dropped_retire", data, 8'h14);

        // channel registers
        wr(2'b00, 8'hA8);
        wr(2'b01, 8'h41);
        cen(1);
        chk("t3_fnumlo", {up_fnumlo, up_ksl_tl}, 2'b10);
        chk("t3_sel_a8", {sel_group, sel_sub}, {2'd2, 3'd2});
        chk("t3_data", data, 8'h41);
        wait_idle();
        wr(2'b00, 8'hC7);
        wr(2'b01, 8'h55);
        cen(1);
        chk("t3_fbcon", {up_fbcon, up_fnumlo}, 2'b10);
        chk("t3_sel_c7", {sel_group, sel_sub}, {2'd2, 3'd1});
        wait_idle();
        wr(2'b00, 8'hB4);
        wr(2'b01, 8'h20);
        cen(1);
        chk("t3_fnumhi_b4", {up_fnumhi, sel_group, sel_sub}, {1'b1, 2'd1, 3'd4});
        wait_idle();
        wr(2'b00, 8'h26);
        wr(2'b01, 8'h01);
        cen(1);
        chk("t3_bad_slot_no_strobe", {up_mult, up_fnumhi}, 2'b00);
        chk("t3_bad_slot_busy", busy, 1);
        wait_idle();

        // OPL3 bank addressing
        wr(2'b10, 8'h20);
        wr(2'b01, 8'h01);
        cen(1);
        chk("t4_bank0_when_old_mode", {sel_bank, up_mult}, 2'b01);
        wait_idle();
        wr(2'b10, 8'h05);
        wr(2'b01, 8'h01);
        cen(1);
        chk("t4_new_mode", new_mode, 1);
        chk("t4_no_strobe_05", up_mult, 0);
        wait_idle();
        wr(2'b10, 8'h20);
        wr(2'b01, 8'h33);
        cen(1);
        chk("t4_bank1_op", {sel_bank, up_mult}, 2'b11);
        wait_idle();
        wr(2'b10, 8'h04);
        wr(2'b01, 8'h3F);
        cen(1);
        chk("t4_conn_sel", conn_sel, 6'h3F);
        chk("t4_bank1_04_no_timer", {st_A, st_B, flagen_A, flagen_B, clr_flag}, 5'b00110);
        wait_idle();

        // timer control and other globals
        wr(2'b00, 8'h04);
        wr(2'b01, 8'h80);
        cen(1);
        chk("t5_clr_flag_set", clr_flag, 1);
        chk("t5_timer_kept", {st_A, st_B, flagen_A, flagen_B}, 4'b0011);
        cen(1);
        chk("t5_clr_flag_clear", clr_flag, 0);
        wait_idle();
        wr(2'b00, 8'h04);
        wr(2'b01, 8'h63);
        cen(1);
        chk("t5_timer_set", {st_A, st_B, flagen_A, flagen_B, clr_flag}, 5'b11000);
        wait_idle();
        wr(2'b00, 8'h02);
        wr(2'b01, 8'h9C);
        cen(1);
        chk("t5_value_A", value_A, 8'h9C);
        wait_idle();
        wr(2'b00, 8'hBD);
        wr(2'b01, 8'hE5);
        cen(1);
        chk("t5_reg_bd", {am_dep, vib_dep, rhy_en, rhy_kon}, {3'b111, 5'b00101});
        wait_idle();
        wr(2'b00, 8'h01);
        wr(2'b01, 8'h00);
        cen(1);
        chk("t5_wave_mode_opl3", wave_mode, 1);
        wait_idle();

        // reset flushes queued writes
        wr(2'b00, 8'h20);
        wr(2'b01, 8'h71);
        wr(2'b01, 8'h72);
        wr(2'b01, 8'h73);
        wr(2'b01, 8'h74);
        cen(1);
        chk("t6_pre_rst_retire", {data, up_mult}, {8'h71, 1'b1});
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ovf", ovf, 0);
        chk("t6_rst_strobes", {up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, up_fnumlo, up_fnumhi, up_fbcon}, 0);
        chk("t6_rst_regs", {new_mode, conn_sel, flagen_A, st_A}, {1'b0, 6'h00, 1'b1, 1'b0});
        cen(30);
        chk("t6_no_stale", {data, busy}, {8'h00, 1'b0});

        // push into full FIFO on a popping clk is accepted
        wr(2'b00, 8'h20);
        wr(2'b01, 8'h81);
        wr(2'b01, 8'h82);
        wr(2'b01, 8'h83);
        wr(2'b01, 8'h84);
        cenop = 1'b1; write = 1'b1; addr = 2'b01; din = 8'h85;
        cyc();
        cenop = 1'b0; write = 1'b0;
        chk("t7_pop_push_data", data, 8'h81);
        chk("t7_pop_push_no_ovf", ovf, 0);
        cen(25);
        chk("t7_ret1", data, 8'h82);
        cen(25);
        chk("t7_ret2", data, 8'h83);
        cen(25);
        chk("t7_ret3", data, 8'h84);
        cen(25);
        chk("t7_ret4", data, 8'h85);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
